// File: rtl/rom_ctrl_pkg.sv
// Shared definitions for the ROM fetch arbiter: FSM state encoding,
// requester IDs and the default read wait-cycle count.
package rom_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } rom_state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DR = 1'b1;

  localparam int unsigned ROM_WAIT_CYCLES_DEFAULT = 1;

  // Reload value for the 4-bit READ down-counter (counts WAIT_CYCLES-1 .. 0).
  function automatic logic [3:0] wait_load(input int unsigned wait_cycles);
    return 4'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/rom_rr_arbiter.sv
// Two-requester grant logic for the ROM port (IF = grant[0], DR = grant[1]).
// Build option ROM_ARB_RR_EN: round-robin with a last-grant register;
// without it, fixed priority with IF always winning.
module rom_rr_arbiter
  import rom_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic       if_valid,
  input  logic       dr_valid,
  output logic [1:0] grant
);

`ifdef ROM_ARB_RR_EN
  logic last_q;
  logic last_d;

  // Contended cycles go to whoever was not served last; a lone requester always wins.
  always_comb begin
    grant = '0;
    if (en) begin
      if (if_valid && dr_valid) begin
        grant = (last_q == REQ_DR) ? 2'b01 : 2'b10;
      end else if (if_valid) begin
        grant = 2'b01;
      end else if (dr_valid) begin
        grant = 2'b10;
      end
    end
  end

  // A grant is always an accept (ready is the grant), so record it every time.
  always_comb begin
    last_d = last_q;
    if (grant[0]) begin
      last_d = REQ_IF;
    end else if (grant[1]) begin
      last_d = REQ_DR;
    end
  end

  // Last-grant register; resets to DR so IF takes the first contended cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= REQ_DR;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{clock, reset_n};

  // Fixed priority: IF beats DR whenever both are valid.
  always_comb begin
    grant = '0;
    if (en) begin
      if (if_valid) begin
        grant = 2'b01;
      end else if (dr_valid) begin
        grant = 2'b10;
      end
    end
  end
`endif

endmodule

// File: rtl/rom_fetch_arbiter.sv
// ROM port sequencer shared by instruction fetch (IF) and read-only data (DR).
// One access at a time: IDLE -> SETUP -> READ (WAIT_CYCLES) -> RESP, or
// IDLE -> RESP directly for a misaligned address (err=1, data=0, ROM untouched).
// Build option ROM_ARB_RR_EN selects round-robin arbitration (see rom_rr_arbiter).
module rom_fetch_arbiter
  import rom_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned WAIT_CYCLES = ROM_WAIT_CYCLES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,

  input  logic              dr_req_valid,
  output logic              dr_req_ready,
  input  logic [ADDR_W-1:0] dr_req_addr,
  output logic              dr_rsp_valid,
  input  logic              dr_rsp_ready,
  output logic [DATA_W-1:0] dr_rsp_data,
  output logic              dr_rsp_err,

  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_chip_select,
  output logic              rom_output_enable,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  rom_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic [1:0]        grant;
  logic [ADDR_W-1:0] sel_addr;
  logic              owner_rsp_ready;

  rom_rr_arbiter u_arb (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (state_q == ST_IDLE),
    .if_valid (if_req_valid),
    .dr_valid (dr_req_valid),
    .grant    (grant)
  );

  assign sel_addr        = grant[1] ? dr_req_addr : if_req_addr;
  assign owner_rsp_ready = (owner_q == REQ_DR) ? dr_rsp_ready : if_rsp_ready;

  // Next-state logic: accept/latch in IDLE, count READ cycles, release on handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    rom_addr_d = rom_addr_q;
    data_d     = data_q;
    err_d      = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          owner_d = grant[1] ? REQ_DR : REQ_IF;
          if (sel_addr[1:0] != 2'b00) begin
            // rom_address is left alone so it only changes for real ROM accesses.
            data_d  = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            rom_addr_d = sel_addr;
            cnt_d      = WAIT_LOAD;
            err_d      = 1'b0;
            state_d    = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          data_d  = rom_data;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (owner_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= REQ_IF;
      rom_addr_q <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      rom_addr_q <= rom_addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  // Output decode from registered state; strobes and response valids never see inputs.
  always_comb begin
    rom_chip_select   = 1'b0;
    rom_output_enable = 1'b0;
    if_rsp_valid      = 1'b0;
    dr_rsp_valid      = 1'b0;
    unique case (state_q)
      ST_SETUP: begin
        rom_chip_select = 1'b1;
      end
      ST_READ: begin
        rom_chip_select   = 1'b1;
        rom_output_enable = 1'b1;
      end
      ST_RESP: begin
        if (owner_q == REQ_DR) begin
          dr_rsp_valid = 1'b1;
        end else begin
          if_rsp_valid = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign if_req_ready = grant[0];
  assign dr_req_ready = grant[1];
  assign rom_address  = rom_addr_q;
  assign if_rsp_data  = data_q;
  assign dr_rsp_data  = data_q;
  assign if_rsp_err   = err_q;
  assign dr_rsp_err   = err_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed self-checking bench for rom_fetch_arbiter: one instance with
// WAIT_CYCLES=1 for most scenarios and one with WAIT_CYCLES=4 for timing.
module tb_rom_fetch_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;

  // WAIT_CYCLES=1 instance
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
  logic [31:0] if_req_addr;
  logic [63:0] if_rsp_data;
  logic        dr_req_valid, dr_req_ready, dr_rsp_valid, dr_rsp_ready, dr_rsp_err;
  logic [31:0] dr_req_addr;
  logic [63:0] dr_rsp_data;
  logic [31:0] rom_address;
  logic        cs, oe;
  logic [63:0] rom_data;

  // WAIT_CYCLES=4 instance
  logic        w4_if_req_valid, w4_if_req_ready, w4_if_rsp_valid, w4_if_rsp_ready, w4_if_rsp_err;
  logic [31:0] w4_if_req_addr;
  logic [63:0] w4_if_rsp_data;
  logic        w4_dr_req_ready, w4_dr_rsp_valid, w4_dr_rsp_err;
  logic [63:0] w4_dr_rsp_data;
  logic [31:0] w4_rom_address;
  logic        w4_cs, w4_oe;
  logic [63:0] w4_rom_data;

  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 64'h0000_0000_9100_07E0;
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  // ROM model: drives a poison pattern whenever it is not being read.
  assign rom_data    = (cs && oe) ? rom_word(rom_address) : 64'hDEAD_BEEF_DEAD_BEEF;
  assign w4_rom_data = (w4_cs && w4_oe) ? rom_word(w4_rom_address) : 64'hDEAD_BEEF_DEAD_BEEF;

  rom_fetch_arbiter #(.ADDR_W(32), .DATA_W(64), .WAIT_CYCLES(1)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err),
    .dr_req_valid(dr_req_valid), .dr_req_ready(dr_req_ready), .dr_req_addr(dr_req_addr),
    .dr_rsp_valid(dr_rsp_valid), .dr_rsp_ready(dr_rsp_ready), .dr_rsp_data(dr_rsp_data),
    .dr_rsp_err(dr_rsp_err),
    .rom_address(rom_address), .rom_chip_select(cs), .rom_output_enable(oe),
    .rom_data(rom_data)
  );

  rom_fetch_arbiter #(.ADDR_W(32), .DATA_W(64), .WAIT_CYCLES(4)) u_dut_w4 (
    .clock(clock), .reset_n(reset_n),
    .if_req_valid(w4_if_req_valid), .if_req_ready(w4_if_req_ready), .if_req_addr(w4_if_req_addr),
    .if_rsp_valid(w4_if_rsp_valid), .if_rsp_ready(w4_if_rsp_ready), .if_rsp_data(w4_if_rsp_data),
    .if_rsp_err(w4_if_rsp_err),
    .dr_req_valid(1'b0), .dr_req_ready(w4_dr_req_ready), .dr_req_addr(32'h0),
    .dr_rsp_valid(w4_dr_rsp_valid), .dr_rsp_ready(1'b1), .dr_rsp_data(w4_dr_rsp_data),
    .dr_rsp_err(w4_dr_rsp_err),
    .rom_address(w4_rom_address), .rom_chip_select(w4_cs), .rom_output_enable(w4_oe),
    .rom_data(w4_rom_data)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin : main
    logic        found;
    logic        exp_dr;
    logic        seen;
    logic [63:0] held;
    int          oe_cnt;
    int          vld_at;

    reset_n = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0; if_rsp_ready = 1'b0;
    dr_req_valid = 1'b0; dr_req_addr = '0; dr_rsp_ready = 1'b0;
    w4_if_req_valid = 1'b0; w4_if_req_addr = '0; w4_if_rsp_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_if_req_ready", 64'(if_req_ready), 64'd0);
    check("rst_dr_req_ready", 64'(dr_req_ready), 64'd0);
    check("rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    check("rst_dr_rsp_valid", 64'(dr_rsp_valid), 64'd0);
    check("rst_rsp_err", 64'({if_rsp_err, dr_rsp_err}), 64'd0);
    check("rst_rsp_data", if_rsp_data | dr_rsp_data, 64'd0);
    check("rst_rom_address", 64'(rom_address), 64'd0);
    check("rst_cs_oe", 64'({cs, oe}), 64'd0);
    reset_n = 1'b1;
    step();

    // IF read of 0x0000, WAIT_CYCLES=1
    if_req_valid = 1'b1; if_req_addr = 32'h0;
    #1;
    check("t1_if_req_ready", 64'(if_req_ready), 64'd1);
    check("t1_dr_req_ready", 64'(dr_req_ready), 64'd0);
    step();                                   // accept edge -> SETUP
    if_req_valid = 1'b0; if_req_addr = 32'hFFFF_FFF0;   // address need not stay stable
    check("t1_setup_cs_oe", 64'({cs, oe}), 64'b10);
    check("t1_setup_addr", 64'(rom_address), 64'h0);
    check("t1_setup_rsp_valid", 64'(if_rsp_valid), 64'd0);
    step();                                   // READ
    check("t1_read_cs_oe", 64'({cs, oe}), 64'b11);
    check("t1_read_rsp_valid", 64'(if_rsp_valid), 64'd0);
    step();                                   // RESP, 3 cycles after accept
    check("t1_resp_cs_oe", 64'({cs, oe}), 64'b00);
    check("t1_if_rsp_valid", 64'(if_rsp_valid), 64'd1);
    check("t1_dr_rsp_valid", 64'(dr_rsp_valid), 64'd0);
    check("t1_data", if_rsp_data, 64'h0000_0000_9100_07E0);
    check("t1_err", 64'(if_rsp_err), 64'd0);
    check("t1_rom_addr_held", 64'(rom_address), 64'h0);
    if_rsp_ready = 1'b1;
    step();                                   // handshake -> IDLE
    check("t1_post_valid", 64'(if_rsp_valid), 64'd0);
    if_rsp_ready = 1'b0;

    // Arbitration: both valid straight out of reset
    reset_n = 1'b0;
    step();
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0008;
    dr_req_valid = 1'b1; dr_req_addr = 32'h0000_0014;
    if_rsp_ready = 1'b1; dr_rsp_ready = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (if_rsp_valid || dr_rsp_valid) begin
          found = 1'b1;
          break;
        end
        step();
      end
      check("arb_rsp_seen", 64'(found), 64'd1);
`ifdef ROM_ARB_RR_EN
      exp_dr = (i % 2 == 1);
`else
      exp_dr = 1'b0;
`endif
      check("arb_owner_dr", 64'(dr_rsp_valid), 64'(exp_dr));
      check("arb_owner_if", 64'(if_rsp_valid), 64'(!exp_dr));
      check("arb_data", exp_dr ? dr_rsp_data : if_rsp_data,
            rom_word(exp_dr ? 32'h14 : 32'h08));
      if (i == 7) if_req_valid = 1'b0;
      step();
    end
    // IF gone: DR alone is granted regardless of history
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (if_rsp_valid || dr_rsp_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("arb_dr_alone_seen", 64'(found), 64'd1);
    check("arb_dr_alone_owner", 64'({dr_rsp_valid, if_rsp_valid}), 64'b10);
    check("arb_dr_alone_data", dr_rsp_data, rom_word(32'h14));
    dr_req_valid = 1'b0;
    step();
    if_rsp_ready = 1'b0; dr_rsp_ready = 1'b0;
    step();

    // DR misaligned 0x0006: error response one cycle after accept, ROM untouched
    dr_req_valid = 1'b1; dr_req_addr = 32'h0000_0006;
    #1;
    check("t3_dr_req_ready", 64'(dr_req_ready), 64'd1);
    step();
    dr_req_valid = 1'b0;
    check("t3_dr_rsp_valid", 64'(dr_rsp_valid), 64'd1);
    check("t3_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    check("t3_err", 64'(dr_rsp_err), 64'd1);
    check("t3_data", dr_rsp_data, 64'd0);
    check("t3_cs", 64'(cs), 64'd0);
    check("t3_rom_addr_held", 64'(rom_address), 64'h14);
    step();
    check("t3_hold_valid", 64'(dr_rsp_valid), 64'd1);
    check("t3_hold_cs", 64'(cs), 64'd0);
    dr_rsp_ready = 1'b1;
    step();
    check("t3_post_valid", 64'(dr_rsp_valid), 64'd0);
    dr_rsp_ready = 1'b0;

    // IF response stalled 10 cycles while DR waits
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0018;
    step();
    if_req_valid = 1'b0;
    step();
    step();
    dr_req_valid = 1'b1; dr_req_addr = 32'h0000_0020;
    held = if_rsp_data;
    check("t4_first_data", held, rom_word(32'h18));
    for (int c = 0; c < 10; c++) begin
      #1;
      check("t4_stall_valid", 64'(if_rsp_valid), 64'd1);
      check("t4_stall_data", if_rsp_data, rom_word(32'h18));
      check("t4_stall_dr_ready", 64'(dr_req_ready), 64'd0);
      check("t4_stall_cs_oe", 64'({cs, oe}), 64'b00);
      step();
    end
    dr_req_valid = 1'b0;
    if_rsp_ready = 1'b1;
    step();
    check("t4_post_valid", 64'(if_rsp_valid), 64'd0);

    // Reset during READ of 0x0010
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0010;
    step();
    if_req_valid = 1'b0;
    step();
    check("t5_in_read", 64'({cs, oe}), 64'b11);
    reset_n = 1'b0;
    #1;
    check("t5_rst_cs_oe", 64'({cs, oe}), 64'b00);
    check("t5_rst_valid", 64'({if_rsp_valid, dr_rsp_valid}), 64'd0);
    check("t5_rst_data", if_rsp_data, 64'd0);
    step();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (if_rsp_valid || dr_rsp_valid) seen = 1'b1;
    end
    check("t5_no_rsp", 64'(seen), 64'd0);
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0020;
    step();
    if_req_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (if_rsp_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t5_next_seen", 64'(found), 64'd1);
    check("t5_next_data", if_rsp_data, rom_word(32'h20));
    check("t5_next_err", 64'(if_rsp_err), 64'd0);
    step();
    if_rsp_ready = 1'b0;

    // WAIT_CYCLES=4: oe high 4 cycles, response 6 cycles after accept
    w4_if_req_valid = 1'b1; w4_if_req_addr = 32'h0000_0028; w4_if_rsp_ready = 1'b1;
    #1;
    check("t6_req_ready", 64'(w4_if_req_ready), 64'd1);
    step();                                   // accept edge; n=0 is SETUP
    w4_if_req_valid = 1'b0;
    oe_cnt = 0;
    vld_at = -1;
    held = '0;
    for (int n = 0; n < 12; n++) begin
      if (w4_oe) begin
        oe_cnt++;
        if (!w4_cs) oe_cnt += 100;
      end
      if (w4_if_rsp_valid && vld_at < 0) begin
        vld_at = n;
        held = w4_if_rsp_data;
      end
      step();
    end
    check("t6_oe_cycles", 64'(oe_cnt), 64'd4);
    check("t6_valid_at", 64'(vld_at), 64'd5);  // SETUP n=0, READ n=1..4, RESP n=5
    check("t6_data", held, rom_word(32'h28));
    check("t6_idle_cs", 64'({w4_cs, w4_oe}), 64'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
